// File: rtl/bfm_apb_slave_mem_pkg.sv
// ============================================================================
// bfm_apb_slave_mem_pkg : shared types and helpers for the APB3 completer BFM
// rev 1.0
// ============================================================================
`default_nettype none

package bfm_apb_slave_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Right-shifting Fibonacci LFSR: bits 0,2,3,5 are taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  // Misaligned, or word index beyond the memory (upper address bits included).
  function automatic logic apb_addr_err(input logic [31:0] paddr, input int unsigned depth);
    return (paddr[1:0] != 2'b00) || ({2'b00, paddr[31:2]} >= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bfm_apb_slave_mem_lfsr16.sv
// ============================================================================
// bfm_lfsr16 : 16-bit Fibonacci LFSR, advances only when step is high
// rev 1.0
// ============================================================================
`default_nettype none

module bfm_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);
  import bfm_apb_slave_mem_pkg::*;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = {^(state_q & LFSR_TAP_MASK), state_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/bfm_apb_slave_mem.sv
// ============================================================================
// bfm_apb_slave_mem : APB3 completer BFM with word memory, wait states, errors
// rev 1.0
// ============================================================================
`default_nettype none

module bfm_apb_slave_mem #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          MAX_WAIT = 15
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  WAITS,
  input  logic        RAND_WAIT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PROT_ERR,
  output logic [15:0] XFER_CNT
);
  import bfm_apb_slave_mem_pkg::*;

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  apb_state_e  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        prot_err_q, prot_err_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  logic [31:0] mem [DEPTH];
  logic        mem_we;
  logic [AW-1:0] rd_idx;
  logic [31:0] rd_word;
  logic        setup_err;
  logic [3:0]  wait_raw, wait_n;
  logic [15:0] lfsr_state;
  logic        lfsr_step;
  logic        unused_lfsr_hi;

  bfm_lfsr16 u_lfsr (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .seed  (SEED),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:4];

  // A zero-wait read needs the word at the address being set up, not the old capture.
  assign rd_idx    = (state_q == ST_IDLE) ? PADDR[AW+1:2] : addr_q[AW+1:2];
  assign rd_word   = mem[rd_idx];
  assign setup_err = apb_addr_err(PADDR, DEPTH);
  assign wait_raw  = RAND_WAIT ? (lfsr_state[3:0] & WAITS) : WAITS;
  assign wait_n    = (wait_raw > MAX_W) ? MAX_W : wait_raw;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    err_d      = err_q;
    prdata_d   = prdata_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prot_err_d = prot_err_q;
    xfer_cnt_d = xfer_cnt_q;
    lfsr_step  = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d    = PADDR;
          write_d   = PWRITE;
          wdata_d   = PWDATA;
          err_d     = setup_err;
          wcnt_d    = wait_n;
          lfsr_step = 1'b1;
          state_d   = ST_ACCESS;
          if (wait_n == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (!PWRITE && !setup_err) ? rd_word : 32'h0;
          end
        end else if (PSEL && PENABLE) begin
          prot_err_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          prot_err_d = 1'b1;
          pready_d   = 1'b0;
          pslverr_d  = 1'b0;
          prdata_d   = 32'h0;
          state_d    = ST_IDLE;
        end else begin
          if ((PADDR != addr_q) || (PWRITE != write_q) || (write_q && (PWDATA != wdata_q))) begin
            prot_err_d = 1'b1;
          end
          if (PENABLE) begin
            if (pready_q) begin
              pready_d   = 1'b0;
              pslverr_d  = 1'b0;
              prdata_d   = 32'h0;
              xfer_cnt_d = xfer_cnt_q + 16'd1;
              mem_we     = write_q && !err_q;
              state_d    = ST_IDLE;
            end else if (wcnt_q != 4'd0) begin
              wcnt_d = wcnt_q - 4'd1;
              if (wcnt_q == 4'd1) begin
                pready_d  = 1'b1;
                pslverr_d = err_q;
                prdata_d  = (!write_q && !err_q) ? rd_word : 32'h0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      prdata_q   <= 32'h0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prot_err_q <= 1'b0;
      xfer_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      err_q      <= err_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prot_err_q <= prot_err_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Memory deliberately has no reset so contents survive PRESETN.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      mem[addr_q[AW+1:2]] <= wdata_q;
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PROT_ERR = prot_err_q;
  assign XFER_CNT = xfer_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bfm_apb_slave_mem.sv
// ============================================================================
// tb_bfm_apb_slave_mem : scoreboard bench for the APB3 completer BFM
// rev 1.0
// ============================================================================
`default_nettype none

module tb_bfm_apb_slave_mem;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PADDR = 32'h0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = 32'h0;
  logic [3:0]  WAITS = 4'h0;
  logic        RAND_WAIT = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PROT_ERR;
  logic [15:0] XFER_CNT;

  bfm_apb_slave_mem dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .WAITS     (WAITS),
    .RAND_WAIT (RAND_WAIT),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PROT_ERR  (PROT_ERR),
    .XFER_CNT  (XFER_CNT)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        slverr;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  int          wait_seen = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts wait cycles and checks every completed transfer.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (PRESETN && PSEL && PENABLE) begin
      if (!PREADY) begin
        wait_seen++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got PREADY at addr %h expected none", PADDR);
        end else begin
          e = exp_q.pop_front();
          check("prdata",  PRDATA,           e.rdata);
          check("pslverr", {31'h0, PSLVERR}, {31'h0, e.slverr});
          check("waits",   wait_seen,        e.waits);
        end
        wait_seen = 0;
      end
    end else begin
      wait_seen = 0;
    end
  end

  // Full transfer; call at posedge+1. Leaves the bus idle at the next posedge+1.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] waits, input logic rnd,
                          input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   n;
    bit   done;
    n = rnd ? int'(lfsr_m[3:0] & waits) : int'(waits);
    if (n > 15) n = 15;
    lfsr_m   = lfsr_next(lfsr_m);
    e.addr   = addr;
    e.rdata  = exp_rdata;
    e.slverr = exp_err;
    e.waits  = n;
    exp_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    WAITS = waits; RAND_WAIT = rnd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no PREADY for addr %h expected within 40 cycles", addr);
      exp_q.delete(exp_q.size() - 1);
    end else begin
      exp_cnt++;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_prdata",   PRDATA,            32'h0);
    check("rst_pready",   {31'h0, PREADY},   32'h0);
    check("rst_pslverr",  {31'h0, PSLVERR},  32'h0);
    check("rst_prot_err", {31'h0, PROT_ERR}, 32'h0);
    check("rst_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
    PRESETN = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait write then read
    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, 1'b0, 32'h0, 1'b0);
    apb_xfer(1'b0, 32'h10, 32'h0,        4'd0, 1'b0, 32'hDEADBEEF, 1'b0);
    check("xfer_cnt_t1", {16'h0, XFER_CNT}, 32'd2);
    apb_xfer(1'b1, 32'h00, 32'h01234567, 4'd0, 1'b0, 32'h0, 1'b0);
    apb_xfer(1'b1, 32'h20, 32'hA5A50020, 4'd1, 1'b0, 32'h0, 1'b0);

    // Fixed three-wait read
    apb_xfer(1'b0, 32'h10, 32'h0, 4'd3, 1'b0, 32'hDEADBEEF, 1'b0);

    // Error addresses: out of range, misaligned, upper bits set
    apb_xfer(1'b1, 32'h400,       32'h1, 4'd0, 1'b0, 32'h0, 1'b1);
    apb_xfer(1'b0, 32'h00,        32'h0, 4'd0, 1'b0, 32'h01234567, 1'b0);
    apb_xfer(1'b0, 32'h402,       32'h0, 4'd2, 1'b0, 32'h0, 1'b1);
    apb_xfer(1'b0, 32'h8000_0010, 32'h0, 4'd0, 1'b0, 32'h0, 1'b1);
    check("xfer_cnt_t3", {16'h0, XFER_CNT}, exp_cnt);

    // Pseudo-random waits against the reference LFSR
    for (int i = 0; i < 20; i++) begin
      if (i % 2 != 0) apb_xfer(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0);
      else            apb_xfer(1'b0, 32'h00, 32'h0, 4'hF, 1'b1, 32'h01234567, 1'b0);
    end
    check("xfer_cnt_t4", {16'h0, XFER_CNT}, exp_cnt);

    // Abort a 5-wait write to 0x20 in its second access cycle
    lfsr_m = lfsr_next(lfsr_m);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'hBAD0BAD0;
    WAITS = 4'd5; RAND_WAIT = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("abort_prot_err", {31'h0, PROT_ERR}, 32'h1);
    check("abort_pready",   {31'h0, PREADY},   32'h0);
    check("abort_xfer_cnt", {16'h0, XFER_CNT}, exp_cnt);
    apb_xfer(1'b0, 32'h20, 32'h0, 4'd0, 1'b0, 32'hA5A50020, 1'b0);

    // Reset in the middle of a write's wait cycles
    apb_xfer(1'b1, 32'h30, 32'h11112222, 4'd2, 1'b0, 32'h0, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h99999999;
    WAITS = 4'd5; RAND_WAIT = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    #1;
    check("midrst_prdata",   PRDATA,            32'h0);
    check("midrst_pready",   {31'h0, PREADY},   32'h0);
    check("midrst_pslverr",  {31'h0, PSLVERR},  32'h0);
    check("midrst_prot_err", {31'h0, PROT_ERR}, 32'h0);
    check("midrst_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
    lfsr_m  = 16'hACE1;
    exp_cnt = 0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 32'h30, 32'h0,        4'd0, 1'b0, 32'h11112222, 1'b0);
    apb_xfer(1'b0, 32'h10, 32'h0,        4'd1, 1'b0, 32'hDEADBEEF, 1'b0);
    apb_xfer(1'b1, 32'h40, 32'h40404040, 4'd0, 1'b0, 32'h0,        1'b0);
    apb_xfer(1'b0, 32'h40, 32'h0,        4'd0, 1'b0, 32'h40404040, 1'b0);
    check("xfer_cnt_after_rst", {16'h0, XFER_CNT}, exp_cnt);

    // Counter wrap from 0xFFFF
    force dut.xfer_cnt_q = 16'hFFFF;
    @(negedge PCLK);
    release dut.xfer_cnt_q;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 32'h40, 32'h0, 4'd2, 1'b0, 32'h40404040, 1'b0);
    check("xfer_cnt_wrap", {16'h0, XFER_CNT}, 32'h0);

    repeat (3) @(posedge PCLK);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
